bwd_recursion: RTL and testbench

//  Max-log-MAP backward (beta) recursion for the 8-state constituent trellis; mirror of the forward (alpha) stage.

---
 rtl/bwd_recursion.sv | 178 +++++++++++++++++
 tb/tb_bwd_recursion.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bwd_recursion.sv
// Max-log-MAP backward (beta) recursion over the 8-state constituent trellis.
// Walks k = N-1 .. 0, fetching LLRs per step and writing normalised beta vectors.
module bwd_recursion #(
  parameter int unsigned W   = 16,
  parameter int unsigned LW  = 8,
  parameter int          NEG = -4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           count_main,
  output logic [7:0]           gm_addr,
  output logic                 gm_rd,
  input  logic signed [LW-1:0] lsys,
  input  logic signed [LW-1:0] lpar,
  output logic signed [W-1:0]  b0,
  output logic signed [W-1:0]  b1,
  output logic signed [W-1:0]  b2,
  output logic signed [W-1:0]  b3,
  output logic signed [W-1:0]  b4,
  output logic signed [W-1:0]  b5,
  output logic signed [W-1:0]  b6,
  output logic signed [W-1:0]  b7,
  output logic [7:0]           beta_addr,
  output logic                 w_r,
  output logic                 done_bwd
);

  localparam int unsigned NS = 8;
  localparam int unsigned AW = 8;
  localparam logic signed [W:0]   SUM_MAX  = (W+1)'((1 << (W-1)) - 1);
  localparam logic signed [W:0]   SUM_MIN  = -SUM_MAX;
  localparam logic signed [W-1:0] NEG_INIT = W'(NEG);

  typedef enum logic [2:0] {IDLE, RD, WT, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic [AW-1:0] k, k_nxt;
  logic [AW-1:0] gm_addr_nxt, beta_addr_nxt;
  logic          gm_rd_nxt, w_r_nxt, done_nxt;
  logic          load_init, upd;

  logic signed [W-1:0] beta_q [NS];
  logic signed [W-1:0] ls_e, lp_e;
  logic signed [W-1:0] gm [4];
  logic signed [W-1:0] cand0 [NS];
  logic signed [W-1:0] cand1 [NS];
  logic signed [W-1:0] best [NS];
  logic signed [W-1:0] norm [NS];

  function automatic logic signed [W-1:0] sat(input logic signed [W:0] x);
    if (x > SUM_MAX)      return SUM_MAX[W-1:0];
    else if (x < SUM_MIN) return SUM_MIN[W-1:0];
    else                  return x[W-1:0];
  endfunction

  function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] x,
                                                  input logic signed [W-1:0] y);
    return sat({x[W-1], x} + {y[W-1], y});
  endfunction

  function automatic logic signed [W-1:0] sat_sub(input logic signed [W-1:0] x,
                                                  input logic signed [W-1:0] y);
    return sat({x[W-1], x} - {y[W-1], y});
  endfunction

  // Successor state for s = {D1,D2,D3} under input u: (a, D1, D2)
  function automatic logic [2:0] nxt_state(input logic [2:0] s, input logic u);
    logic a;
    a = u ^ s[1] ^ s[0];
    return {a, s[2], s[1]};
  endfunction

  function automatic logic par_bit(input logic [2:0] s, input logic u);
    logic a;
    a = u ^ s[1] ^ s[0];
    return a ^ s[2] ^ s[0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (count_main == '0) ? DONE : RD;
      RD:      state_nxt = WT;
      WT:      state_nxt = CALC;
      CALC:    state_nxt = (k == '0) ? DONE : RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the step counter and registered control outputs
  always_comb begin
    k_nxt         = k;
    gm_addr_nxt   = gm_addr;
    beta_addr_nxt = beta_addr;
    load_init     = 1'b0;
    upd           = 1'b0;
    case (state)
      IDLE: if (start) begin
        k_nxt     = count_main - AW'(1);
        load_init = 1'b1;
      end
      CALC: if (k != '0) k_nxt = k - AW'(1);
      default: ;
    endcase
    gm_rd_nxt = (state_nxt == RD);
    w_r_nxt   = (state_nxt == CALC);
    done_nxt  = (state_nxt == DONE);
    if (gm_rd_nxt) gm_addr_nxt = k_nxt;
    if (w_r_nxt) begin
      beta_addr_nxt = k;
      upd           = 1'b1;
    end
  end

  // Branch metrics, add-compare-select and normalisation against state 0
  always_comb begin
    ls_e  = {{(W-LW){lsys[LW-1]}}, lsys};
    lp_e  = {{(W-LW){lpar[LW-1]}}, lpar};
    gm[0] = -ls_e - lp_e;
    gm[1] = -ls_e + lp_e;
    gm[2] =  ls_e - lp_e;
    gm[3] =  ls_e + lp_e;
    for (int s = 0; s < NS; s++) begin
      cand0[s] = sat_add(beta_q[nxt_state(3'(s), 1'b0)],
                         gm[{1'b0, par_bit(3'(s), 1'b0)}]);
      cand1[s] = sat_add(beta_q[nxt_state(3'(s), 1'b1)],
                         gm[{1'b1, par_bit(3'(s), 1'b1)}]);
      best[s]  = (cand1[s] > cand0[s]) ? cand1[s] : cand0[s];
    end
    for (int s = 0; s < NS; s++) begin
      norm[s] = sat_sub(best[s], best[0]);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k         <= '0;
      gm_addr   <= '0;
      gm_rd     <= 1'b0;
      beta_addr <= '0;
      w_r       <= 1'b0;
      done_bwd  <= 1'b0;
      beta_q[0] <= '0;
      for (int s = 1; s < NS; s++) beta_q[s] <= NEG_INIT;
      b0 <= '0; b1 <= '0; b2 <= '0; b3 <= '0;
      b4 <= '0; b5 <= '0; b6 <= '0; b7 <= '0;
    end else begin
      k         <= k_nxt;
      gm_addr   <= gm_addr_nxt;
      gm_rd     <= gm_rd_nxt;
      beta_addr <= beta_addr_nxt;
      w_r       <= w_r_nxt;
      done_bwd  <= done_nxt;
      if (load_init) begin
        beta_q[0] <= '0;
        for (int s = 1; s < NS; s++) beta_q[s] <= NEG_INIT;
      end else if (upd) begin
        for (int s = 0; s < NS; s++) beta_q[s] <= norm[s];
      end
      if (upd) begin
        b0 <= norm[0]; b1 <= norm[1]; b2 <= norm[2]; b3 <= norm[3];
        b4 <= norm[4]; b5 <= norm[5]; b6 <= norm[6]; b7 <= norm[7];
      end
    end
  end

endmodule

// File: tb/tb_bwd_recursion.sv
// Scoreboard bench for bwd_recursion: a max-log model pushes expected beta vectors,
// a negedge monitor pops and compares them on every write strobe.
module tb_bwd_recursion;

  localparam int NEGV = -4096;
  localparam int SMAX = 32767;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        count_main = '0;
  logic [7:0]        gm_addr;
  logic              gm_rd;
  logic signed [7:0] lsys = '0;
  logic signed [7:0] lpar = '0;
  logic signed [15:0] b0, b1, b2, b3, b4, b5, b6, b7;
  logic [7:0]        beta_addr;
  logic              w_r;
  logic              done_bwd;

  bwd_recursion dut (
    .clk(clk), .rst(rst), .start(start), .count_main(count_main),
    .gm_addr(gm_addr), .gm_rd(gm_rd), .lsys(lsys), .lpar(lpar),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7),
    .beta_addr(beta_addr), .w_r(w_r), .done_bwd(done_bwd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int addr;
    int b[8];
  } exp_t;

  exp_t sb[$];
  logic signed [7:0] ls_mem [256];
  logic signed [7:0] lp_mem [256];
  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    if (x > SMAX)  return SMAX;
    if (x < -SMAX) return -SMAX;
    return x;
  endfunction

  // Golden max-log model over the LLR memory contents
  task automatic push_expected(input int n);
    int beta [8];
    int bnew [8];
    exp_t e;
    beta[0] = 0;
    for (int s = 1; s < 8; s++) beta[s] = NEGV;
    for (int k = n - 1; k >= 0; k--) begin
      int ls, lp;
      ls = ls_mem[k];
      lp = lp_mem[k];
      for (int s = 0; s < 8; s++) begin
        int bst;
        bst = 0;
        for (int u = 0; u < 2; u++) begin
          int d1, d2, d3, a, p, nx, g, c;
          d1 = (s >> 2) & 1;
          d2 = (s >> 1) & 1;
          d3 = s & 1;
          a  = u ^ d2 ^ d3;
          p  = a ^ d1 ^ d3;
          nx = a * 4 + d1 * 2 + d2;
          g  = (u != 0 ? ls : -ls) + (p != 0 ? lp : -lp);
          c  = sat(beta[nx] + g);
          if (u == 0 || c > bst) bst = c;
        end
        bnew[s] = bst;
      end
      for (int s = 0; s < 8; s++) e.b[s] = sat(bnew[s] - bnew[0]);
      for (int s = 0; s < 8; s++) beta[s] = e.b[s];
      e.addr = k;
      sb.push_back(e);
    end
  endtask

  // LLR memory: answers a read strobe with data for the following cycle
  always @(negedge clk) begin
    if (gm_rd) begin
      lsys = ls_mem[gm_addr];
      lpar = lp_mem[gm_addr];
    end
  end

  // Write-strobe monitor
  always @(negedge clk) begin
    exp_t e;
    int got [8];
    if (gm_rd) rd_cnt++;
    if (gm_rd && w_r) check("rd_wr_overlap", 1, 0);
    if (w_r) begin
      wr_cnt++;
      got[0] = b0; got[1] = b1; got[2] = b2; got[3] = b3;
      got[4] = b4; got[5] = b5; got[6] = b6; got[7] = b7;
      check("b0_zero", got[0], 0);
      for (int s = 0; s < 8; s++)
        check($sformatf("range_b%0d", s), int'(got[s] >= -SMAX && got[s] <= SMAX), 1);
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("beta_addr", int'(beta_addr), e.addr);
        for (int s = 0; s < 8; s++)
          check($sformatf("b%0d@k%0d", s, e.addr), got[s], e.b[s]);
      end
    end
  end

  task automatic fill(input int mode, input int ls, input int lp);
    for (int i = 0; i < 256; i++) begin
      if (mode == 0) begin
        ls_mem[i] = 8'(ls);
        lp_mem[i] = 8'(lp);
      end else begin
        ls_mem[i] = 8'($urandom_range(0, 255));
        lp_mem[i] = 8'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gm_addr"}, int'(gm_addr), 0);
    check({tag, "_gm_rd"}, int'(gm_rd), 0);
    check({tag, "_beta_addr"}, int'(beta_addr), 0);
    check({tag, "_w_r"}, int'(w_r), 0);
    check({tag, "_done"}, int'(done_bwd), 0);
    check({tag, "_b_or"}, int'(|{b0, b1, b2, b3, b4, b5, b6, b7}), 0);
  endtask

  // One full recursion with latency, strobe-count and scoreboard-drain checks
  task automatic run(input int n, input string tag, input bit disturb);
    int  t0;
    bit  seen;
    sb.delete();
    wr_cnt = 0;
    rd_cnt = 0;
    push_expected(n);
    @(negedge clk);
    count_main = 8'(n);
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      repeat (4) @(negedge clk);
      count_main = 8'(n + 5);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < 3 * n + 40 && !seen; i++) begin
      if (done_bwd) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_latency"}, seen ? cyc - t0 : -1, 3 * n + 1);
    count_main = '0;
    @(negedge clk);
    check({tag, "_done_pulse"}, int'(done_bwd), 0);
    repeat (4) @(negedge clk);
    check({tag, "_wr_cnt"}, wr_cnt, n);
    check({tag, "_rd_cnt"}, rd_cnt, n);
    check({tag, "_sb_left"}, sb.size(), 0);
  endtask

  initial begin
    bit seen;
    int bad;

    // Reset state
    fill(0, 0, 0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // N=1, zero LLRs
    run(1, "n1_zero", 1'b0);
    check("n1_b1_const", int'(b1), 0);
    check("n1_b2_const", int'(b2), NEGV);

    // Abort in the middle of a CALC cycle
    fill(0, 10, 10);
    sb.delete();
    push_expected(3);
    @(negedge clk);
    count_main = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (w_r) seen = 1'b1;
      else @(negedge clk);
    end
    check("abort_reached_calc", int'(seen), 1);
    #1 rst = 1'b0;
    #1 check_zero("abort");
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_bwd || w_r || gm_rd) bad++;
    end
    check("abort_quiet", bad, 0);

    // Clean run after reset
    fill(0, 0, 0);
    run(1, "n1_after_rst", 1'b0);

    // N=3, all +10
    fill(0, 10, 10);
    run(3, "n3_pos10", 1'b0);

    // N=0
    run(0, "n0", 1'b0);

    // N=255, all +127
    fill(0, 127, 127);
    run(255, "n255_max", 1'b0);

    // Second start and count_main change mid-run
    fill(1, 0, 0);
    run(4, "n4_disturb", 1'b1);

    // Random LLRs, including extremes
    fill(1, 0, 0);
    ls_mem[3] = -8'sd128;
    lp_mem[3] = -8'sd128;
    ls_mem[7] = 8'sd127;
    lp_mem[7] = -8'sd128;
    run(20, "n20_rand", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
